// File: rtl/comp_serial_ctrl.sv
// Sequencing controller for a bit-serial magnitude comparator: walks two latched
// operands MSB-first, stops at the first differing bit and reports eq/gt/lt.
module comp_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    nbits
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             busy_nxt, done_nxt, eq_nxt, gt_nxt, lt_nxt;
    logic [CW-1:0]    nbits_nxt;
    logic             bit_a, bit_b;

    assign bit_a = a_q[idx];
    assign bit_b = b_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            nbits <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            eq    <= eq_nxt;
            gt    <= gt_nxt;
            lt    <= lt_nxt;
            nbits <= nbits_nxt;
        end
    end

    // The running count lives in cnt so an aborted compare leaves the
    // previously reported nbits untouched; nbits loads only with a result.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        eq_nxt    = eq;
        gt_nxt    = gt;
        lt_nxt    = lt;
        nbits_nxt = nbits;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    idx_nxt   = IW'(WIDTH - 1);
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (bit_a != bit_b) begin
                        gt_nxt    = bit_a;
                        lt_nxt    = bit_b;
                        eq_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                        nbits_nxt = cnt + CW'(1);
                        busy_nxt  = 1'b0;
                        state_nxt = S_DONE;
                    end else if (idx == '0) begin
                        eq_nxt    = 1'b1;
                        gt_nxt    = 1'b0;
                        lt_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                        nbits_nxt = cnt + CW'(1);
                        busy_nxt  = 1'b0;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt = idx - IW'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed bench for comp_serial_ctrl (WIDTH=8) with hand-computed expectations.
module tb_comp_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, eq, gt, lt;
    logic [3:0] nbits;

    int n_vec = 0;
    int n_err = 0;

    comp_serial_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt),
        .nbits (nbits)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge (edge 0) from a settled IDLE; samples #1 after it.
    task automatic do_start(input logic [7:0] av, input logic [7:0] bv);
        repeat (2) @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after edge 0 until done; n=-1 if the 20-edge budget expires.
    task automatic wait_done(output int n, output bit busy_ok);
        n = -1;
        busy_ok = busy;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        bit bok;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, eq, gt, lt, nbits} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_init: got %b expected 0", {busy, done, eq, gt, lt, nbits});
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(8'hA5, 8'h25);
        wait_done(n, bok);
        do_start(8'h3C, 8'h3C);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, eq, gt, lt, nbits} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_midrun: got %b expected 0", {busy, done, eq, gt, lt, nbits});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_compare(input logic [7:0] av, input logic [7:0] bv,
                                input int exp_n, input logic [2:0] exp_egl);
        int n;
        bit bok;
        do_start(av, bv);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise %h/%h: got %b expected 1", av, bv, busy);
        end
        wait_done(n, bok);
        n_vec++;
        if (n !== exp_n) begin
            n_err++;
            $display("FAIL latency %h/%h: got %0d expected %0d", av, bv, n, exp_n);
        end
        n_vec++;
        if ({eq, gt, lt} !== exp_egl || nbits !== 4'(exp_n)) begin
            n_err++;
            $display("FAIL result %h/%h: eq/gt/lt=%b nbits=%0d expected %b %0d",
                     av, bv, {eq, gt, lt}, nbits, exp_egl, exp_n);
        end
        n_vec++;
        if (bok !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_window %h/%h: held=%b at_done=%b expected 1 0", av, bv, bok, busy);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0 || {eq, gt, lt} !== exp_egl || nbits !== 4'(exp_n)) begin
            n_err++;
            $display("FAIL done_pulse_hold %h/%h: done=%b egl=%b nbits=%0d expected 0 %b %0d",
                     av, bv, done, {eq, gt, lt}, nbits, exp_egl, exp_n);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        // A5/25 resolves in one bit: accept, result, DONE -> period of 3 edges.
        repeat (2) @(negedge clk);
        a = 8'hA5;
        b = 8'h25;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            exp_done = (k % 3 == 1);
            exp_busy = (k % 3 == 0);
            n_vec++;
            if (done !== exp_done || busy !== exp_busy) begin
                n_err++;
                $display("FAIL b2b_edge%0d: done=%b busy=%b expected %b %b",
                         k, done, busy, exp_done, exp_busy);
            end
        end
        start = 1'b0;
        // 10/11 then FF/00 with start held and operands swapped mid-run.
        repeat (3) @(negedge clk);
        a = 8'h10;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'h00;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            exp_done = (k == 8) || (k == 11);
            n_vec++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL hold_edge%0d: done=%b expected %b", k, done, exp_done);
            end
            if (k == 8) begin
                n_vec++;
                if ({eq, gt, lt} !== 3'b001 || nbits !== 4'd8) begin
                    n_err++;
                    $display("FAIL operand_change: egl=%b nbits=%0d expected 001 8", {eq, gt, lt}, nbits);
                end
            end
            if (k == 11) begin
                n_vec++;
                if ({eq, gt, lt} !== 3'b010 || nbits !== 4'd1) begin
                    n_err++;
                    $display("FAIL second_accept: egl=%b nbits=%0d expected 010 1", {eq, gt, lt}, nbits);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        test_compare(8'hA5, 8'h25, 1, 3'b010);
        do_start(8'h01, 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || {eq, gt, lt} !== 3'b010 || nbits !== 4'd1) begin
            n_err++;
            $display("FAIL abort_edge3: busy=%b done=%b egl=%b nbits=%0d expected 0 0 010 1",
                     busy, done, {eq, gt, lt}, nbits);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_quiet%0d: done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
        // start with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        a = 8'h00;
        b = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_blocks_start: busy=%b expected 0", busy);
        end
        test_compare(8'h40, 8'h50, 4, 3'b001);
    endtask

    initial begin
        test_reset();
        test_compare(8'hA5, 8'h25, 1, 3'b010);
        test_compare(8'h3C, 8'h3C, 8, 3'b100);
        test_compare(8'h10, 8'h11, 8, 3'b001);
        test_compare(8'h40, 8'h50, 4, 3'b001);
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
